// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only, single-port data RAM with a 1-cycle registered read.
// Partial stores are read-modify-write; misaligned or illegal requests return an error and never touch memory.
module load_store_unit #(
    parameter int D = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [2:0]    i_req_funct3,
    input  logic [31:0]   i_req_addr,
    input  logic [31:0]   i_req_wdata,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_rdata,
    output logic          o_rsp_err,
    output logic [D-1:0]  o_mem_addr,
    output logic [31:0]   o_mem_data,
    output logic          o_mem_we,
    input  logic [31:0]   i_mem_data
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wlo_q;
    logic        req_err;
    logic        accept;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Upper address bits alias; only the word index and lane bits matter.
    logic unused_addr;
    assign unused_addr = ^{i_req_addr[31:D+2], i_req_wdata[31:16]};

    assign accept      = (state == IDLE) && i_req_valid;
    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == RESP);
    assign o_mem_we    = (state == WR);

    always_comb begin
        req_err = 1'b0;
        case (i_req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = i_req_addr[0];
            3'b010:  req_err = |i_req_addr[1:0];
            3'b100:  req_err = i_req_we;
            3'b101:  req_err = i_req_we | i_req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (i_req_we && (i_req_funct3 == 3'b010))
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = i_rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane extraction and merge both work on the word returned in WAIT.
    always_comb begin
        sel_byte = i_mem_data[{lane_q, 3'b000} +: 8];
        sel_half = i_mem_data[{lane_q[1], 4'b0000} +: 16];
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{sel_byte[7] & ~f3_q[2]}}, sel_byte};
            2'b01:   load_ext = {{16{sel_half[15] & ~f3_q[2]}}, sel_half};
            default: load_ext = i_mem_data;
        endcase
        merged = i_mem_data;
        if (f3_q[0])
            merged[{lane_q[1], 4'b0000} +: 16] = wlo_q;
        else
            merged[{lane_q, 3'b000} +: 8] = wlo_q[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            wlo_q       <= 16'h0000;
            o_rsp_rdata <= 32'h0000_0000;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q        <= i_req_we;
                f3_q        <= i_req_funct3;
                lane_q      <= i_req_addr[1:0];
                wlo_q       <= i_req_wdata[15:0];
                o_mem_addr  <= i_req_addr[D+1:2];
                o_mem_data  <= i_req_wdata;
                o_rsp_rdata <= 32'h0000_0000;
                o_rsp_err   <= req_err;
            end else if (state == WAIT) begin
                if (we_q)
                    o_mem_data <= merged;
                else
                    o_rsp_rdata <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM (registered read, no byte enables).
module tb_load_store_unit;

    localparam int D = 8;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [D-1:0]  mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    logic [31:0]   ram [0:(1<<D)-1];
    int            we_cnt;
    logic [31:0]   last_waddr;
    logic [31:0]   last_wdata;
    int            checks;
    int            errors;

    load_store_unit #(.D(D)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_wdata),
        .o_mem_we     (mem_we),
        .i_mem_data   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
            last_waddr    <= 32'(mem_addr);
            last_wdata    <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, measure accept-to-response latency, optionally stall the response.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wes, input int hold);
        int lat;
        int we0;
        we0 = we_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_vld"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
            chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".idle"}, 32'(req_ready), 32'd1);
        chk({tag, ".wes"}, 32'(we_cnt - we0), 32'(exp_wes));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        we_cnt     = 0;
        last_waddr = 32'h0;
        last_wdata = 32'h0;
        for (int i = 0; i < (1 << D); i++) ram[i] = 32'h0;
        ram[5]     = 32'h8070_F0A1;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.rsp_vld", 32'(rsp_valid), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_data", mem_wdata, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // tag, we, funct3, addr, wdata, rdata, err, latency, writes, hold
        do_req("lb",   1'b0, 3'b000, 32'h15, 32'h0, 32'hFFFF_FFF0, 1'b0, 3, 0, 0);
        do_req("lbu",  1'b0, 3'b100, 32'h15, 32'h0, 32'h0000_00F0, 1'b0, 3, 0, 0);
        do_req("lh",   1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_8070, 1'b0, 3, 0, 0);
        do_req("lhu",  1'b0, 3'b101, 32'h14, 32'h0, 32'h0000_F0A1, 1'b0, 3, 0, 0);
        do_req("lb0",  1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 0, 0);

        do_req("sw",   1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 0);
        chk("sw.waddr", last_waddr, 32'd8);
        chk("sw.wdata", last_wdata, 32'hDEAD_BEEF);
        do_req("lw",   1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0, 0);

        do_req("sb",   1'b1, 3'b000, 32'h22, 32'h1234_5655, 32'h0, 1'b0, 4, 1, 0);
        chk("sb.wdata", last_wdata, 32'hDE55_BEEF);
        do_req("sh",   1'b1, 3'b001, 32'h20, 32'h0000_CAFE, 32'h0, 1'b0, 4, 1, 0);
        chk("sh.wdata", last_wdata, 32'hDE55_CAFE);
        chk("sh.ram", ram[8], 32'hDE55_CAFE);

        do_req("lw_mis",  1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("sh_mis",  1'b1, 3'b001, 32'h23, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("ld_f011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("st_f100", 1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        chk("err.ram", ram[8], 32'hDE55_CAFE);

        do_req("lw_hold", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDE55_CAFE, 1'b0, 3, 0, 5);
        do_req("lw_next", 1'b0, 3'b010, 32'h14, 32'h0, 32'h8070_F0A1, 1'b0, 3, 0, 0);

        // Reset lands in the WAIT state of an SB; the write must never happen.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000_0077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst.mem_we", 32'(mem_we), 32'd0);
        chk("arst.mem_addr", 32'(mem_addr), 32'd0);
        chk("arst.mem_data", mem_wdata, 32'd0);
        chk("arst.rsp_vld", 32'(rsp_valid), 32'd0);
        chk("arst.rdata", rsp_rdata, 32'd0);
        chk("arst.err", 32'(rsp_err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.ready", 32'(req_ready), 32'd1);
        chk("arst.ram", ram[8], 32'hDE55_CAFE);
        do_req("arst.lw", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDE55_CAFE, 1'b0, 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
